// File: rtl/pattern_player_pkg.sv
// Shared types and constants for pattern_player: FSM states, signature defaults,
// MISR feedback taps and the program step record.
package pattern_player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int SIG_W_DEF  = 8;
  localparam int HOLD_W_DEF = 4;
  // The hold field is sized for the widest supported hold count; narrower
  // configurations zero-extend into it.
  localparam int HOLD_W_MAX = 16;

  // Feedback taps sig[7], sig[5], sig[4], sig[3].
  localparam logic [SIG_W_DEF-1:0] MISR_TAPS = 8'hB8;

  typedef struct packed {
    logic [2:0]            vec;
    logic [HOLD_W_MAX-1:0] hold;
  } step_t;

endpackage

// File: rtl/pattern_misr.sv
// Single-input signature register: shifts left, feeding back the XOR of the
// tapped bits with the response bit. Clear has priority over enable.
module pattern_misr
  import pattern_player_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] TAPS  = SIG_W'(MISR_TAPS)
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], (^(sig_q & TAPS)) ^ din_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pattern_player.sv
// Programmable A/B/C stimulus player with response signature.
// Optional macro PATTERN_PLAYER_LOOP_EN adds a `loop` input for continuous replay.
//
// Handshake: a write is accepted on any edge where wr_en=1 and busy=0; start is
// accepted only in IDLE. Both sampled on the same edge: the write lands first.
module pattern_player
  import pattern_player_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int SIG_W  = SIG_W_DEF
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [2:0]               wr_vec,
  input  logic [HOLD_W-1:0]        wr_hold,
  input  logic [$clog2(DEPTH):0]   num_steps,
  input  logic                     start,
  input  logic                     out_in,
`ifdef PATTERN_PLAYER_LOOP_EN
  input  logic                     loop,
`endif
  output logic                     A,
  output logic                     B,
  output logic                     C,
  output logic                     busy,
  output logic                     done,
  output logic [SIG_W-1:0]         sig,
  output state_e                   state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  step_t         mem_q [DEPTH];
  state_e        state_q, state_d;
  logic [AW-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NW-1:0] nsteps_q, nsteps_d;

  step_t cur;
  logic  playing, hold_last, step_last, loop_now, sig_clr, sig_en;

`ifdef PATTERN_PLAYER_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign playing = (state_q == PLAY);

  // Program memory is deliberately left out of reset so a program survives an abort.
  always_ff @(posedge clk) begin
    if (wr_en && !playing) begin
      mem_q[wr_addr] <= '{vec: wr_vec, hold: HOLD_W_MAX'(wr_hold)};
    end
  end

  assign cur       = mem_q[step_q];
  assign hold_last = (cur.hold == '0) ||
                     (HOLD_W_MAX'(hold_q) == cur.hold - HOLD_W_MAX'(1));
  assign step_last = ({1'b0, step_q} == nsteps_q - NW'(1));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    hold_d   = hold_q;
    nsteps_d = nsteps_q;
    sig_clr  = 1'b0;
    sig_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_clr  = 1'b1;
          step_d   = '0;
          hold_d   = '0;
          nsteps_d = (num_steps > NW'(DEPTH)) ? NW'(DEPTH) : num_steps;
          state_d  = (num_steps == '0) ? FIN : PLAY;
        end
      end
      PLAY: begin
        sig_en = 1'b1;
        if (hold_last) begin
          hold_d = '0;
          if (!step_last) begin
            step_d = step_q + AW'(1);
          end else if (loop_now) begin
            step_d = '0;
          end else begin
            state_d = FIN;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q  <= IDLE;
      step_q   <= '0;
      hold_q   <= '0;
      nsteps_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      nsteps_q <= nsteps_d;
    end
  end

  pattern_misr #(
    .SIG_W(SIG_W),
    .TAPS (SIG_W'(MISR_TAPS))
  ) u_misr (
    .clk_i(clk),
    .res_i(res),
    .clr_i(sig_clr),
    .en_i (sig_en),
    .din_i(out_in),
    .sig_o(sig)
  );

  assign A         = playing & cur.vec[2];
  assign B         = playing & cur.vec[1];
  assign C         = playing & cur.vec[0];
  assign busy      = playing;
  assign done      = (state_q == FIN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player: per-cycle expected {busy,done,A,B,C}
// trace queued at start, popped and compared each cycle, plus signature checks.
module tb_pattern_player;
  import pattern_player_pkg::*;

  localparam int DEPTH  = 8;
  localparam int HOLD_W = 4;
  localparam int SIG_W  = 8;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [2:0] wr_vec = '0;
  logic [HOLD_W-1:0] wr_hold = '0;
  logic [3:0] num_steps = '0;
  logic start = 1'b0;
  logic out_in = 1'b0;
  logic A, B, C, busy, done;
  logic [SIG_W-1:0] sig;
  state_e state_dbg;

  logic [2:0] m_vec [DEPTH];
  logic [HOLD_W-1:0] m_hold [DEPTH];
  logic [4:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  pattern_player #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .SIG_W(SIG_W)) dut (
    .clk(clk), .res(res), .wr_en(wr_en), .wr_addr(wr_addr), .wr_vec(wr_vec),
    .wr_hold(wr_hold), .num_steps(num_steps), .start(start), .out_in(out_in),
`ifdef PATTERN_PLAYER_LOOP_EN
    .loop(1'b0),
`endif
    .A(A), .B(B), .C(C), .busy(busy), .done(done), .sig(sig),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_step(input int addr, input logic [2:0] v, input logic [HOLD_W-1:0] h);
    wr_en = 1'b1; wr_addr = addr[2:0]; wr_vec = v; wr_hold = h;
    tick();
    wr_en = 1'b0;
    m_vec[addr] = v; m_hold[addr] = h;
  endtask

  // mode: 0 = out_in low, 1 = out_in high only in the last PLAY cycle, 2 = random.
  // inj: mid-playback write to step0 plus a re-start, both of which must be ignored.
  // wws: write step0 in the same cycle as start; playback must use the new data.
  task automatic play(input int n, input int mode, input bit inj, input bit wws,
                      input logic [2:0] wv, input logic [HOLD_W-1:0] wh);
    int ne, pc, idx, h;
    logic [7:0] s;
    logic [4:0] e;
    bit o;
    if (wws) begin
      m_vec[0] = wv; m_hold[0] = wh;
    end
    ne = (n > DEPTH) ? DEPTH : n;
    pc = 0;
    for (int k = 0; k < ne; k++) begin
      h = (m_hold[k] == 0) ? 1 : int'(m_hold[k]);
      for (int c = 0; c < h; c++) begin
        exp_q.push_back({2'b10, m_vec[k]});
        pc++;
      end
    end
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b00000);
    num_steps = n[3:0];
    start = 1'b1;
    if (wws) begin
      wr_en = 1'b1; wr_addr = '0; wr_vec = wv; wr_hold = wh;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    s = '0; idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("trace", {27'd0, busy, done, A, B, C}, {27'd0, e});
      o = (mode == 0) ? 1'b0 : (mode == 1) ? (idx == pc - 1) : 1'($urandom_range(0, 1));
      out_in = o;
      if (e[4]) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ o};
      if (inj && idx == 1) begin
        wr_en = 1'b1; wr_addr = '0; wr_vec = 3'b111; wr_hold = 4'd5; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      idx++;
      tick();
    end
    out_in = 1'b0;
    check("sig", {24'd0, sig}, {24'd0, s});
  endtask

  initial begin
    // Reset held with start asserted
    res = 1'b0; start = 1'b1; num_steps = 4'd2;
    tick(); tick();
    check("rst_outs", {27'd0, busy, done, A, B, C}, 32'd0);
    check("rst_sig", {24'd0, sig}, 32'd0);
    start = 1'b0;
    res = 1'b1;
    tick();
    check("idle_outs", {27'd0, busy, done, A, B, C}, 32'd0);

    // Basic two-step program
    write_step(0, 3'b011, 4'd3);
    write_step(1, 3'b101, 4'd0);
    play(2, 0, 1'b0, 1'b0, '0, '0);
    check("sig_zero", {24'd0, sig}, 32'h00);
    play(2, 1, 1'b0, 1'b0, '0, '0);
    check("sig_one", {24'd0, sig}, 32'h01);

    // Zero steps: done next cycle, signature cleared
    play(0, 2, 1'b0, 1'b0, '0, '0);
    check("sig_clr0", {24'd0, sig}, 32'h00);

    // Busy protection, then replay shows original step0
    play(2, 2, 1'b1, 1'b0, '0, '0);
    play(2, 2, 1'b0, 1'b0, '0, '0);

    // Write and start in the same cycle
    play(2, 2, 1'b0, 1'b1, 3'b110, 4'd2);

    // Full random program, exact depth and clamped
    for (int i = 0; i < DEPTH; i++) begin
      write_step(i, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 4)));
    end
    play(DEPTH, 2, 1'b0, 1'b0, '0, '0);
    play(12, 2, 1'b0, 1'b0, '0, '0);
    play(3, 2, 1'b0, 1'b0, '0, '0);

    // Abort midway through step1
    write_step(0, 3'b011, 4'd3);
    write_step(1, 3'b101, 4'd4);
    num_steps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    out_in = 1'b1;
    repeat (4) tick();
    check("abort_pre", {27'd0, busy, done, A, B, C}, {27'd0, 5'b10101});
    res = 1'b0;
    tick();
    check("abort_outs", {27'd0, busy, done, A, B, C}, 32'd0);
    check("abort_sig", {24'd0, sig}, 32'd0);
    res = 1'b1; out_in = 1'b0;
    tick();
    check("abort_nodone", {27'd0, busy, done, A, B, C}, 32'd0);
    play(2, 2, 1'b0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
Programmable stimulus driver for the three-input `sequential` block: the driving end of its A/B/C/out interface.
- Stores up to DEPTH steps. Each step is a 3-bit vector {A,B,C} plus a hold count.
- On start, plays the steps onto A, B, C cycle-accurately.
- Compresses the returned `out` bit into a signature register, so the block can replace hand-written stimulus in self-checking benches.

Parameters:
DEPTH, 8, number of program steps (power of 2, >=2)
HOLD_W, 4, width of per-step hold count
SIG_W, 8, signature register width

Ports:
clk  in  1  clock; all logic on the rising edge
res  in  1  synchronous, active-low reset
wr_en  in  1  program write strobe; accepted only when busy=0
wr_addr  in  $clog2(DEPTH)  step index to write
wr_vec  in  3  step vector, {A,B,C} = wr_vec[2:0]
wr_hold  in  HOLD_W  hold cycles for the step; 0 treated as 1
num_steps  in  $clog2(DEPTH)+1  steps to play, sampled at start
start  in  1  begin playback; ignored while busy=1
out_in  in  1  response bit from the driven block
A  out  1  stimulus bit (wr_vec[2])
B  out  1  stimulus bit (wr_vec[1])
C  out  1  stimulus bit (wr_vec[0])
busy  out  1  high during playback
done  out  1  one-cycle pulse after the last step completes
sig  out  SIG_W  response signature

Behaviour:
- Reset (res=0 at a clk edge): state=IDLE; A=B=C=0, busy=0, done=0, sig=0, step/hold counters=0. Program memory is not reset and keeps its contents. Reset mid-playback aborts immediately with no done pulse.
- Writes: when wr_en=1 and busy=0, mem[wr_addr] <= {wr_vec, wr_hold} at the edge. Writes while busy=1 are dropped. Write and start in the same cycle: the write lands first; playback sees the new data.
- States: IDLE, PLAY, FIN.
  - IDLE --start & num_steps>0--> PLAY.
  - IDLE --start & num_steps==0--> FIN. No stimulus; done pulses one cycle after the start edge.
  - PLAY --last hold cycle of step num_steps-1--> FIN.
  - FIN --> IDLE, unconditionally, one cycle later.
- Latency: if start is sampled at edge t, A/B/C = mem[0].vec and busy=1 from edge t onward. Step k is driven for max(hold_k,1) consecutive cycles, then step k+1 follows with no gap.
- In FIN: A=B=C=0, busy=0, done=1 for exactly one cycle. In IDLE, done=0.
- num_steps > DEPTH is clamped to DEPTH.
- Signature: on every cycle in PLAY, sig <= {sig[SIG_W-2:0], sig[SIG_W-1]^sig[5]^sig[4]^sig[3]^out_in} (taps fixed for SIG_W=8). sig is cleared on the start edge and holds its value in FIN and IDLE.
- out_in is sampled in the same cycle the stimulus is driven. No pipeline compensation is applied; the bench accounts for DUT latency.

Optional Feature:
PATTERN_PLAYER_LOOP_EN
- Defined: adds input `loop`. If loop=1 when the last step ends, playback restarts at step 0 with no gap cycle and no done pulse; sig keeps accumulating. Deasserting loop lets the current pass finish normally, ending with FIN and done.
- Not defined: no `loop` port; playback always ends after one pass.

Decomposition:
- Package pattern_player_pkg: state enum (IDLE, PLAY, FIN), SIG_W default, MISR tap constants, step record typedef {vec[2:0], hold[HOLD_W-1:0]}.
- One sub-module, pattern_misr: signature register with clear, enable, data-in and sig output.

Test Plan:
- Reset: hold res=0 for 2 cycles with start=1 -> A=B=C=0, busy=0, done=0, sig=0.
- Basic: program step0={011,hold 3}, step1={101,hold 0}; num_steps=2; start -> ABC=011 for 3 cycles, then 101 for 1 cycle, then FIN with done=1 for 1 cycle, busy low.
- Zero steps: num_steps=0, start -> no ABC change; done pulses on the next cycle.
- Signature: out_in=0 throughout -> sig=0x00. out_in=1 only in the last PLAY cycle -> sig=0x01.
- Busy protection: during playback, write step0={111} and re-assert start -> neither takes effect; a later replay shows the original step0.
- Abort: res=0 midway through step1 -> outputs 0 next edge, no done; a following start replays from step0.
